// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, MISS, REFILL, DONE} state_e;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - offset_w(line_words) - index_w(sets);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a, input int line_words);
    return (a >> 2) & 32'(line_words - 1);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] a, input int sets,
                                           input int line_words);
    return (a >> offset_w(line_words)) & 32'(sets - 1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a, input int sets,
                                         input int line_words);
    return a >> (offset_w(line_words) + index_w(sets));
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch request/response and memory-bridge burst signals of the instruction cache.
interface icache_dm_if #(parameter int ADDR_W = 32);

  logic              ICache_valid;
  logic [ADDR_W-1:0] addr;
  logic              ICache_ready;
  logic [31:0]       rdata;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;

  // The cache side: serves fetches, masters the refill bus.
  modport slave (
    input  ICache_valid, addr, rd_rdy, ret_valid, ret_last, ret_data,
    output ICache_ready, rdata, rd_req, rd_addr
  );

  // The environment side: fetch stage plus memory bridge.
  modport master (
    output ICache_valid, addr, rd_rdy, ret_valid, ret_last, ret_data,
    input  ICache_ready, rdata, rd_req, rd_addr
  );

endinterface

// File: rtl/icache_refill_buf.sv
// Line buffer collecting refill beats; exposes the line with the in-flight beat merged
// so the final beat can be committed on the same edge it arrives.
module icache_refill_buf
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                beat_valid,
  input  logic                                beat_last,
  input  logic [DATA_W-1:0]                   beat_data,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]   line,
  output logic                                complete
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  logic [CNT_W-1:0]                 cnt_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (beat_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_valid) begin
      line_q[cnt_q] <= beat_data;
    end
  end

  always_comb begin
    line = line_q;
    if (beat_valid) begin
      line[cnt_q] = beat_data;
    end
  end

  assign complete = beat_valid & beat_last;

endmodule

// File: rtl/icache_dm.sv
// Blocking direct-mapped read-only instruction cache with 0-cycle hits and
// whole-line refill over a burst read bridge.
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WORD_W   = $clog2(LINE_WORDS);

  state_e state_q, state_d;

  logic [31:0]        addr32;
  logic [WORD_W-1:0]  req_word;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;

  logic [WORD_W-1:0]  cap_word_q;
  logic [INDEX_W-1:0] cap_index_q;
  logic [TAG_W-1:0]   cap_tag_q;

  logic [SETS-1:0]                   valid_q;
  logic [TAG_W-1:0]                  tag_q  [SETS];
  logic [LINE_WORDS-1:0][DATA_W-1:0] data_q [SETS];

  logic                              hit;
  logic                              same_req;
  logic                              cap_en;
  logic                              fill_start;
  logic                              beat_en;
  logic                              commit;
  logic [LINE_WORDS-1:0][DATA_W-1:0] fill_line;
  logic                              fill_complete;

  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rd_req;

  assign addr32    = 32'(bus.addr);
  assign req_word  = WORD_W'(word_of(addr32, LINE_WORDS));
  assign req_index = INDEX_W'(index_of(addr32, SETS, LINE_WORDS));
  assign req_tag   = TAG_W'(tag_of(addr32, SETS, LINE_WORDS));

  assign hit      = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign same_req = (req_tag == cap_tag_q) && (req_index == cap_index_q) &&
                    (req_word == cap_word_q);
  assign beat_en  = bus.ret_valid && (state_q == REFILL);

  icache_refill_buf #(.LINE_WORDS(LINE_WORDS)) u_refill_buf (
    .clk        (clk),
    .rst        (rst),
    .start      (fill_start),
    .beat_valid (beat_en),
    .beat_last  (bus.ret_last),
    .beat_data  (bus.ret_data),
    .line       (fill_line),
    .complete   (fill_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        valid_q[cap_index_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_word_q  <= req_word;
      cap_index_q <= req_index;
      cap_tag_q   <= req_tag;
    end
    if (commit) begin
      tag_q[cap_index_q]  <= cap_tag_q;
      data_q[cap_index_q] <= fill_line;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    rdata      = '0;
    rd_req     = 1'b0;
    cap_en     = 1'b0;
    fill_start = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ICache_valid) begin
          if (hit) begin
            ready = 1'b1;
            rdata = data_q[req_index][req_word];
          end else begin
            cap_en  = 1'b1;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        rd_req = 1'b1;
        if (bus.rd_rdy) begin
          fill_start = 1'b1;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (fill_complete) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A request that was dropped and replaced by a different one is left to IDLE.
        if (bus.ICache_valid && same_req) begin
          ready = 1'b1;
          rdata = fill_line[cap_word_q];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ICache_ready = ready;
  assign bus.rdata        = rdata;
  assign bus.rd_req       = rd_req;
  assign bus.rd_addr      = rd_req ? {cap_tag_q, cap_index_q, OFFSET_W'(0)} : '0;

endmodule

// File: tb/tb_icache_dm.sv
// Directed plus randomized fetch sequences against a residency/memory model of the cache.
module tb_icache_dm;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] salt;

  bit          m_valid [64];
  logic [31:0] m_tag   [64];

  always #5 clk = ~clk;

  icache_dm_if #(.ADDR_W(32)) bus ();

  icache_dm #(.ADDR_W(32), .SETS(64), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00} ^ salt;
    return (w * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic fetch(input logic [31:0] a, input int delay, input int drop_beat);
    logic [31:0] line_a;
    int          idx;
    logic [31:0] tg;
    line_a = a & ~32'hF;
    idx    = int'((a / 16) % 64);
    tg     = a / 1024;
    bus.ICache_valid = 1'b1;
    bus.addr         = a;
    @(negedge clk);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      chk("hit_ready", 32'(bus.ICache_ready), 32'd1);
      chk("hit_rdata", bus.rdata, mem_word(a));
      chk("hit_rd_req", 32'(bus.rd_req), 32'd0);
      @(posedge clk); #1;
      bus.ICache_valid = 1'b0;
      return;
    end
    chk("miss_ready", 32'(bus.ICache_ready), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < delay; c++) begin
      @(negedge clk);
      chk("wait_rd_req", 32'(bus.rd_req), 32'd1);
      chk("wait_rd_addr", bus.rd_addr, line_a);
      chk("wait_ready", 32'(bus.ICache_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rd_rdy = 1'b1;
    @(negedge clk);
    chk("req_rd_req", 32'(bus.rd_req), 32'd1);
    chk("req_rd_addr", bus.rd_addr, line_a);
    @(posedge clk); #1;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == drop_beat) bus.ICache_valid = 1'b0;
      bus.ret_valid = 1'b1;
      bus.ret_last  = (i == 3);
      bus.ret_data  = mem_word(line_a + 32'(4 * i));
      @(negedge clk);
      chk("refill_ready", 32'(bus.ICache_ready), 32'd0);
      chk("refill_rd_req", 32'(bus.rd_req), 32'd0);
      @(posedge clk); #1;
    end
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    @(negedge clk);
    if (drop_beat >= 0) begin
      chk("dropped_ready", 32'(bus.ICache_ready), 32'd0);
    end else begin
      chk("done_ready", 32'(bus.ICache_ready), 32'd1);
      chk("done_rdata", bus.rdata, mem_word(a));
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(posedge clk); #1;
    bus.ICache_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    int          delay;
    int          drop;

    salt             = $urandom;
    rst              = 1'b1;
    bus.ICache_valid = 1'b0;
    bus.addr         = '0;
    bus.rd_rdy       = 1'b0;
    bus.ret_valid    = 1'b0;
    bus.ret_last     = 1'b0;
    bus.ret_data     = '0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ICache_ready), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, then neighbouring word hits immediately.
    fetch(32'h1C00_0000, 0, -1);
    fetch(32'h1C00_0004, 0, -1);
    @(negedge clk);
    chk("idle_no_valid_ready", 32'(bus.ICache_ready), 32'd0);
    @(posedge clk); #1;

    // Conflict eviction on index 0.
    fetch(32'h1C00_0400, 0, -1);
    fetch(32'h1C00_0000, 1, -1);

    // Bridge stalls the request for five cycles.
    fetch(32'h1C00_0018, 5, -1);

    // Requester walks away mid-refill; the line still installs.
    fetch(32'h1C00_0024, 1, 2);
    fetch(32'h1C00_002C, 0, -1);

    // Asynchronous reset part-way through a refill.
    a = 32'h1C00_0830;
    bus.ICache_valid = 1'b1;
    bus.addr         = a;
    @(posedge clk); #1;
    bus.rd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ret_valid = 1'b1;
      bus.ret_data  = mem_word((a & ~32'hF) + 32'(4 * i));
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_req", 32'(bus.rd_req), 32'd0);
    chk("arst_ready", 32'(bus.ICache_ready), 32'd0);
    chk("arst_rdata", bus.rdata, 32'd0);
    bus.ret_valid    = 1'b0;
    bus.ICache_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(a, 0, -1);
    fetch(32'h1C00_0000, 0, -1);

    // Random traffic over a few conflicting tags and low indices.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       base = 32'h1C00_0000;
        1:       base = 32'h1C00_0400;
        default: base = 32'h2000_0000;
      endcase
      a     = base + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
      delay = int'($urandom_range(0, 3));
      drop  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, delay, drop);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("rand_idle_ready", 32'(bus.ICache_ready), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
